// File: rtl/cursor_accel.sv
// cursor_accel: five-button cursor with press / hold-delay / auto-repeat / accelerate
// motion on X and Y, plus a rate-limited fire strobe carrying the latched position.
// Optional build macro: CURSOR_WRAP_EN (coordinates wrap at the bounds instead of saturating).
module cursor_accel #(
    parameter int unsigned OUTWIDTH      = 8,
    parameter int unsigned STEP          = 5,
    parameter int unsigned FAST_STEP     = 10,
    parameter int unsigned XMIN          = 10,
    parameter int unsigned XMAX          = 245,
    parameter int unsigned YMIN          = 10,
    parameter int unsigned YMAX          = 245,
    parameter int unsigned XINIT         = 128,
    parameter int unsigned YINIT         = 128,
    parameter int unsigned HOLD_TICKS    = 20,
    parameter int unsigned REPEAT_TICKS  = 6,
    parameter int unsigned FAST_AFTER    = 8,
    parameter int unsigned FIRE_COOLDOWN = 30
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_tick,
    input  logic                i_btnR,
    input  logic                i_btnL,
    input  logic                i_btnU,
    input  logic                i_btnD,
    input  logic                i_btnC,
    output logic [OUTWIDTH-1:0] o_xcursor,
    output logic [OUTWIDTH-1:0] o_ycursor,
    output logic                o_fire,
    output logic [OUTWIDTH-1:0] o_fire_x,
    output logic [OUTWIDTH-1:0] o_fire_y,
    output logic                o_moving
);

    localparam int unsigned PW      = OUTWIDTH + 1;
    localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);
    localparam int unsigned REP_W   = $clog2(FAST_AFTER + 2);
    localparam int unsigned CD_W    = $clog2(FIRE_COOLDOWN + 2);

    typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_t;

    // One bounded move, evaluated one bit wider than the coordinate so pos+step cannot overflow.
    function automatic logic [OUTWIDTH-1:0] f_step(
        input logic [OUTWIDTH-1:0] pos,
        input logic                up,
        input logic [PW-1:0]       amt,
        input logic [PW-1:0]       lo,
        input logic [PW-1:0]       hi
    );
        logic [PW-1:0] w_p;
        logic [PW-1:0] w_r;
        w_p = {1'b0, pos};
        if (up) begin
            if (w_p + amt > hi) begin
`ifdef CURSOR_WRAP_EN
                w_r = lo;
`else
                w_r = hi;
`endif
            end else begin
                w_r = w_p + amt;
            end
        end else begin
            if (w_p < lo + amt) begin
`ifdef CURSOR_WRAP_EN
                w_r = hi;
`else
                w_r = lo;
`endif
            end else begin
                w_r = w_p - amt;
            end
        end
        return w_r[OUTWIDTH-1:0];
    endfunction

    // Index 0 is X (R = +, L = -), index 1 is Y (D = +, U = -).
    logic [1:0]            w_inc_btn;
    logic [1:0]            w_dec_btn;
    logic [2*OUTWIDTH-1:0] w_pos_flat;
    logic [1:0]            w_busy;

    assign w_inc_btn = {i_btnD, i_btnR};
    assign w_dec_btn = {i_btnU, i_btnL};

    for (genvar a = 0; a < 2; a++) begin : g_axis
        localparam logic [PW-1:0]       LO   = (a == 0) ? PW'(XMIN) : PW'(YMIN);
        localparam logic [PW-1:0]       HI   = (a == 0) ? PW'(XMAX) : PW'(YMAX);
        localparam logic [OUTWIDTH-1:0] INIT = (a == 0) ? OUTWIDTH'(XINIT) : OUTWIDTH'(YINIT);

        state_t              r_state;
        logic [CNT_W-1:0]    r_cnt;
        logic [REP_W-1:0]    r_rep;
        logic                r_dir;
        logic [OUTWIDTH-1:0] r_pos;
        logic                w_req;
        logic                w_req_up;
        logic                w_same;
        logic [PW-1:0]       w_rep_amt;

        // Decode the request and whether it continues the latched direction.
        always_comb begin
            w_req     = w_inc_btn[a] ^ w_dec_btn[a];
            w_req_up  = w_inc_btn[a];
            w_same    = w_req && (w_req_up == r_dir);
            w_rep_amt = (r_rep >= REP_W'(FAST_AFTER)) ? PW'(FAST_STEP) : PW'(STEP);
        end

        // Axis FSM: advances only on tick cycles; any release or reversal drops back to idle.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_rep   <= '0;
                r_dir   <= 1'b0;
                r_pos   <= INIT;
            end else if (i_tick) begin
                unique case (r_state)
                    StIdle: begin
                        if (w_req) begin
                            r_pos   <= f_step(r_pos, w_req_up, PW'(STEP), LO, HI);
                            r_dir   <= w_req_up;
                            r_cnt   <= '0;
                            r_state <= StHold;
                        end
                    end
                    StHold: begin
                        if (!w_same) begin
                            r_state <= StIdle;
                        end else if (r_cnt == CNT_W'(HOLD_TICKS - 1)) begin
                            r_pos   <= f_step(r_pos, r_dir, PW'(STEP), LO, HI);
                            r_cnt   <= '0;
                            r_rep   <= '0;
                            r_state <= StRepeat;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (!w_same) begin
                            r_state <= StIdle;
                        end else if (r_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
                            r_pos <= f_step(r_pos, r_dir, w_rep_amt, LO, HI);
                            r_cnt <= '0;
                            if (r_rep < REP_W'(FAST_AFTER)) begin
                                r_rep <= r_rep + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end

        assign w_pos_flat[a*OUTWIDTH +: OUTWIDTH] = r_pos;
        assign w_busy[a]                          = (r_state != StIdle);
    end

    logic                r_btnc_q;
    logic                r_fire;
    logic [OUTWIDTH-1:0] r_fire_x;
    logic [OUTWIDTH-1:0] r_fire_y;
    logic [CD_W-1:0]     r_cool;
    logic                w_fire_go;

    // Rising edge of btnC fires only once the cooldown has drained; edges during cooldown are lost.
    assign w_fire_go = i_btnC & ~r_btnc_q & (r_cool == '0);

    // Fire strobe, position capture (pre-move values) and tick-paced cooldown.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btnc_q <= 1'b1;  // a button held through reset must not fire
            r_fire   <= 1'b0;
            r_fire_x <= '0;
            r_fire_y <= '0;
            r_cool   <= '0;
        end else begin
            r_btnc_q <= i_btnC;
            if (w_fire_go) begin
                r_fire   <= 1'b1;
                r_fire_x <= w_pos_flat[0 +: OUTWIDTH];
                r_fire_y <= w_pos_flat[OUTWIDTH +: OUTWIDTH];
                r_cool   <= CD_W'(FIRE_COOLDOWN);
            end else begin
                r_fire <= 1'b0;
                if (i_tick && (r_cool != '0)) begin
                    r_cool <= r_cool - 1'b1;
                end
            end
        end
    end

    assign o_xcursor = w_pos_flat[0 +: OUTWIDTH];
    assign o_ycursor = w_pos_flat[OUTWIDTH +: OUTWIDTH];
    assign o_fire    = r_fire;
    assign o_fire_x  = r_fire_x;
    assign o_fire_y  = r_fire_y;
    assign o_moving  = |w_busy;

endmodule

// File: tb/tb_cursor_accel.sv
// Self-checking bench for cursor_accel: directed vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural model.
module tb_cursor_accel;

    localparam int OW    = 8;
    localparam int STEP  = 5;
    localparam int FAST  = 10;
    localparam int XMIN  = 10;
    localparam int XMAX  = 245;
    localparam int YMIN  = 10;
    localparam int YMAX  = 245;
    localparam int XI    = 128;
    localparam int YI    = 128;
    localparam int HT    = 3;
    localparam int RT    = 2;
    localparam int FA    = 2;
    localparam int FC    = 4;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // Button vector order: {C, D, U, L, R}
    localparam logic [4:0] B0 = 5'b00000;
    localparam logic [4:0] BR = 5'b00001;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BU = 5'b00100;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BC = 5'b10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [4:0]    btn;
    logic [OW-1:0] x, y, fx, fy;
    logic          fire, moving;

    cursor_accel #(
        .OUTWIDTH(OW), .STEP(STEP), .FAST_STEP(FAST),
        .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
        .XINIT(XI), .YINIT(YI),
        .HOLD_TICKS(HT), .REPEAT_TICKS(RT), .FAST_AFTER(FA), .FIRE_COOLDOWN(FC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .i_btnR(btn[0]), .i_btnL(btn[1]), .i_btnU(btn[2]), .i_btnD(btn[3]), .i_btnC(btn[4]),
        .o_xcursor(x), .o_ycursor(y), .o_fire(fire),
        .o_fire_x(fx), .o_fire_y(fy), .o_moving(moving)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Per axis: held = number of ticks since the press tick (0 = idle).
    int m_pos[2];
    int m_held[2];
    int m_ldir[2];
    int m_since;
    bit m_prevc;
    bit m_fire;
    int m_fx, m_fy;

    function automatic int model_move(int p, int dir, int amt, int lo, int hi);
        int r;
        if (dir > 0) begin
            r = p + amt;
            if (r > hi) r = WRAP ? lo : hi;
        end else begin
            r = p - amt;
            if (r < lo) r = WRAP ? hi : lo;
        end
        return r;
    endfunction

    task automatic model_step();
        int inc, dec, dir, n, j, lo, hi;
        if (rst) begin
            m_pos[0] = XI; m_pos[1] = YI;
            m_held[0] = 0; m_held[1] = 0;
            m_since = FC; m_prevc = 1'b1; m_fire = 1'b0; m_fx = 0; m_fy = 0;
            return;
        end
        if (btn[4] && !m_prevc && m_since >= FC) begin
            m_fire = 1'b1; m_fx = m_pos[0]; m_fy = m_pos[1]; m_since = 0;
        end else begin
            m_fire = 1'b0;
            if (tick && m_since < FC) m_since++;
        end
        m_prevc = btn[4];
        if (!tick) return;
        for (int a = 0; a < 2; a++) begin
            inc = (a == 0) ? int'(btn[0]) : int'(btn[3]);
            dec = (a == 0) ? int'(btn[1]) : int'(btn[2]);
            dir = (inc != 0 && dec == 0) ? 1 : (dec != 0 && inc == 0) ? -1 : 0;
            lo  = (a == 0) ? XMIN : YMIN;
            hi  = (a == 0) ? XMAX : YMAX;
            if (m_held[a] == 0) begin
                if (dir != 0) begin
                    m_pos[a]  = model_move(m_pos[a], dir, STEP, lo, hi);
                    m_held[a] = 1;
                    m_ldir[a] = dir;
                end
            end else if (dir == 0 || dir != m_ldir[a]) begin
                m_held[a] = 0;
            end else begin
                n = m_held[a];
                if (n == HT) begin
                    m_pos[a] = model_move(m_pos[a], dir, STEP, lo, hi);
                end else if (n > HT && (n - HT) % RT == 0) begin
                    j = (n - HT) / RT;  // j-th auto-repeat move after the first
                    m_pos[a] = model_move(m_pos[a], dir, (j > FA) ? FAST : STEP, lo, hi);
                end
                m_held[a]++;
            end
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {30'd0, x, y, fire, fx, fy, moving};
    endfunction

    function automatic logic [63:0] model_vec();
        logic mv;
        mv = (m_held[0] != 0) || (m_held[1] != 0);
        return {30'd0, OW'(m_pos[0]), OW'(m_pos[1]), m_fire, OW'(m_fx), OW'(m_fy), mv};
    endfunction

    // One clock: model follows the edge, outputs sampled 1ns later.
    task automatic do_cycle(input string name);
        @(posedge clk);
        model_step();
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    // Taps a direction once (one tick pressed, one tick released).
    task automatic tap(input logic [4:0] b);
        btn = b;  do_cycle("tap_press");
        btn = B0; do_cycle("tap_release");
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic [4:0]    btn;
        logic [OW-1:0] x, y;
        logic          f;
        logic [OW-1:0] fx, fy;
        logic          mv;
    } vec_t;

    function automatic vec_t mk(logic r, logic [4:0] b, int ex, int ey, logic ef, int efx, int efy,
                                logic emv);
        vec_t v;
        v.rst = r; v.btn = b; v.x = OW'(ex); v.y = OW'(ey); v.f = ef;
        v.fx = OW'(efx); v.fy = OW'(efy); v.mv = emv;
        return v;
    endfunction

    vec_t tbl[28];
    int   hold_x[12] = '{133, 133, 133, 138, 138, 143, 143, 148, 148, 158, 158, 168};

    initial begin
        logic [OW-1:0] prev_y;
        logic [OW-1:0] x0;
        logic [63:0]   exp_v;

        rst = 1'b1; tick = 1'b1; btn = B0;

        tbl[0]  = mk(1, B0, 128, 128, 0, 0, 0, 0);
        tbl[1]  = mk(0, BR, 133, 128, 0, 0, 0, 1);
        tbl[2]  = mk(0, B0, 133, 128, 0, 0, 0, 0);
        tbl[3]  = mk(0, B0, 133, 128, 0, 0, 0, 0);
        tbl[4]  = mk(0, BC, 133, 128, 1, 133, 128, 0);
        tbl[5]  = mk(0, B0, 133, 128, 0, 133, 128, 0);
        tbl[6]  = mk(0, BC, 133, 128, 0, 133, 128, 0);
        tbl[7]  = mk(0, B0, 133, 128, 0, 133, 128, 0);
        tbl[8]  = mk(0, B0, 133, 128, 0, 133, 128, 0);
        tbl[9]  = mk(0, BC, 133, 128, 1, 133, 128, 0);
        tbl[10] = mk(0, B0, 133, 128, 0, 133, 128, 0);
        tbl[11] = mk(1, B0, 128, 128, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tbl[12 + i] = mk(0, BR, hold_x[i], 128, 0, 0, 0, 1);
        tbl[24] = mk(1, BR, 128, 128, 0, 0, 0, 0);
        tbl[25] = mk(0, BR, 133, 128, 0, 0, 0, 1);
        tbl[26] = mk(1, BC, 128, 128, 0, 0, 0, 0);
        tbl[27] = mk(0, BC, 128, 128, 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            rst = tbl[i].rst;
            btn = tbl[i].btn;
            do_cycle("model_tbl");
            exp_v = {30'd0, tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].fx, tbl[i].fy, tbl[i].mv};
            check($sformatf("vec%0d", i), dut_vec(), exp_v);
        end

        // Hold U until well past the lower bound: monotone, never below YMIN, ends at YMIN.
        rst = 1'b1; btn = B0; do_cycle("rst_y");
        rst = 1'b0; btn = BU;
        prev_y = y;
        for (int i = 0; i < 40; i++) begin
            do_cycle("hold_u");
            check("y_mono_bound", 64'(y <= prev_y && y >= OW'(YMIN)), 64'd1);
            prev_y = y;
        end
        check("y_at_min", 64'(y), 64'(YMIN));

        // Opposing X buttons cancel: no motion, X FSM stays idle.
        btn = B0; do_cycle("release_u");
        x0 = x;
        btn = BL | BR;
        for (int i = 0; i < 6; i++) begin
            do_cycle("l_and_r");
            check("lr_x_hold", 64'({x, moving}), 64'({x0, 1'b0}));
        end

        // Bound behaviour on X: 128 + 23*5 = 243, 128 - 23*5 = 13 (the 5-step grid from 128).
        rst = 1'b1; btn = B0; do_cycle("rst_xh");
        rst = 1'b0;
        for (int i = 0; i < 23; i++) tap(BR);
        check("x_243", 64'(x), 64'd243);
        tap(BR);
        check("x_over_max", 64'(x), WRAP ? 64'(XMIN) : 64'(XMAX));
        rst = 1'b1; do_cycle("rst_xl");
        rst = 1'b0;
        for (int i = 0; i < 23; i++) tap(BL);
        check("x_13", 64'(x), 64'd13);
        tap(BL);
        check("x_under_min", 64'(x), WRAP ? 64'(XMAX) : 64'(XMIN));

        // Randomized phase: sticky direction buttons, toggling btnC, gapped ticks, rare resets.
        rst = 1'b1; btn = B0; do_cycle("rst_rand");
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 6))
                    0: btn[3:0] = 4'b0000;
                    1: btn[3:0] = BR[3:0];
                    2: btn[3:0] = BL[3:0];
                    3: btn[3:0] = BU[3:0];
                    4: btn[3:0] = BD[3:0];
                    5: btn[3:0] = BR[3:0] | BD[3:0];
                    default: btn[3:0] = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) btn[4] = ~btn[4];
            tick = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 299) == 0);
            do_cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cursor_accel.md
Name: cursor_accel

Overview:
- Second-generation player cursor for the NORAD-A targeting display.
- Converts the five board buttons into saturating X/Y cursor coordinates. Motion follows a press / hold-delay / auto-repeat / accelerate profile, paced by an external tick strobe (frame or ms tick).
- Also produces a rate-limited fire strobe carrying the cursor position latched at the fire moment.
- Sits between the button synchronisers and the vector renderer / missile-launch logic.

Parameters:
- OUTWIDTH, 8: coordinate width.
- STEP, 5: normal step per move.
- FAST_STEP, 10: accelerated step.
- XMIN, 10 / XMAX, 245: X bounds, inclusive.
- YMIN, 10 / YMAX, 245: Y bounds, inclusive.
- XINIT, 128 / YINIT, 128: reset position.
- HOLD_TICKS, 20: ticks in HOLD before the first auto-repeat move.
- REPEAT_TICKS, 6: ticks between auto-repeat moves.
- FAST_AFTER, 8: repeat moves at STEP before switching to FAST_STEP.
- FIRE_COOLDOWN, 30: ticks after a fire during which btnC is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle motion/cooldown pacing strobe
- btnR, btnL, btnU, btnD, btnC  in  1 each  synchronised buttons, active-high
- xcursor  out  OUTWIDTH  current X, registered
- ycursor  out  OUTWIDTH  current Y, registered (btnD increases Y, btnU decreases Y)
- fire  out  1  one-cycle fire pulse
- fire_x, fire_y  out  OUTWIDTH  coordinates captured with fire; held until the next fire
- moving  out  1  high while either axis FSM is not IDLE

Behaviour:
- One clock domain. Reset is synchronous, active-high, and dominates tick and all buttons.
- Reset values: xcursor=XINIT, ycursor=YINIT, fire=0, fire_x=0, fire_y=0, moving=0, both FSMs IDLE, counters 0, cooldown 0, btnC history register=1 (so a button held through reset does not fire).
- Axis request:
  - X: dir=+1 if btnR&~btnL; dir=-1 if btnL&~btnR; else 0.
  - Y: the same, using btnD (+1) and btnU (-1).
  - The two axes are independent identical FSMs; diagonal motion is allowed.
- Axis FSMs evaluate only on cycles with tick=1 and hold state otherwise. Buttons are sampled on tick cycles only.
- IDLE: if dir!=0, move by STEP in dir, latch dir, cnt=0, go to HOLD.
- HOLD:
  - If dir==0 or dir!=latched, go to IDLE with no move. A reversal therefore costs one tick.
  - Else if cnt==HOLD_TICKS-1, move by STEP, cnt=0, rep=0, go to REPEAT.
  - Else cnt++.
- REPEAT:
  - If dir==0 or dir!=latched, go to IDLE.
  - Else if cnt==REPEAT_TICKS-1, move by (rep>=FAST_AFTER ? FAST_STEP : STEP), cnt=0, rep++ (saturating at FAST_AFTER).
  - Else cnt++.
- Move latency: a coordinate changes on the clock edge ending the tick cycle, so it is visible one cycle after the tick.
- Arithmetic: computed at OUTWIDTH+1 bits.
  - Increment: if pos+step>MAX then MAX, else pos+step.
  - Decrement: if pos<MIN+step then MIN, else pos-step.
  - The result is never outside [MIN,MAX]. A move while already at the bound is legal and leaves pos unchanged; the FSM still advances.
- Fire:
  - Fires on a btnC rising edge (btnC & ~btnC_q, sampled every clk, not gated by tick) when cooldown==0.
  - On fire: fire=1 for exactly one cycle; fire_x/fire_y capture the xcursor/ycursor register values present in that cycle, i.e. before any same-cycle move; cooldown loads FIRE_COOLDOWN.
  - cooldown decrements on tick cycles and stops at 0.
  - Edges seen while cooldown!=0 are dropped, not queued.
- Reset mid-hold: all state returns to reset values. A button still held after reset is treated as a fresh press on the next tick.

Optional Feature:
- Macro CURSOR_WRAP_EN.
- Defined: motion wraps instead of saturating. An increment that would exceed MAX yields MIN; a decrement that would go below MIN yields MAX. All other behaviour is unchanged.
- Undefined: saturating behaviour as specified above.

Test Plan:
(Parameter overrides for all scenarios: HOLD_TICKS=3, REPEAT_TICKS=2, FAST_AFTER=2, FIRE_COOLDOWN=4, tick=1 every cycle.)
- Reset, then 1-tick btnR press and release -> xcursor 128→133; FSM returns to IDLE; moving falls; ycursor stays 128.
- Hold btnR from reset for 12 ticks -> xcursor takes values 133 (tick0), 138 (t3), 143 (t5), 148 (t7), 158 (t9), 168 (t11).
- Hold btnU for 40 ticks -> ycursor decreases monotonically, reaches exactly 10, stays 10, and never reads below 10. btnL+btnR held together -> xcursor unchanged, X FSM stays IDLE.
- btnC rise at (133,128) -> fire high for 1 cycle with fire_x=133, fire_y=128. Second rise 2 ticks later -> no fire. Rise after ≥4 ticks -> fire again.
- Assert rst during REPEAT with btnR held -> next cycle x=128, moving=0. Release rst with btnR still held -> x=133 after the next tick.
- With CURSOR_WRAP_EN and x=243, btnR press -> x=10. With x=12, btnL press -> x=245.
